// File: rtl/control_fsm.sv
// Multi-cycle RV32I main control unit. A Moore FSM sequences fetch, decode,
// execute, memory and writeback, and stalls on a single-bit memory ready.
module control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_cond,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       is_imm,
  output logic [2:0] imm_src,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR1    = 4'd11,
    S_JALR2    = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  state_t     state_q;
  state_t     state_d;

  logic       pc_update_s;
  logic       branch_s;
  logic       ir_write_s;
  logic       mem_write_s;
  logic       reg_write_s;
  logic       adr_src_s;
  logic [1:0] result_src_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic       is_imm_s;
  logic       illegal_s;
  logic [2:0] imm_src_s;

  // State register; reset returns to FETCH immediately, aborting any instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_d      = state_q;
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    ir_write_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    adr_src_s    = 1'b0;
    result_src_s = 2'b00;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    is_imm_s     = 1'b0;
    illegal_s    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        ir_write_s   = mem_ready;
        pc_update_s  = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // Precompute old PC + imm so BRANCH finds the target in ALUOut.
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_IMM:            state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR1;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        if (opcode == OP_STORE) begin
          state_d = S_MEMWRITE;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        adr_src_s = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_EXECR: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b10;
        is_imm_s    = 1'b1;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b01;
        branch_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL, S_JALR2: begin
        // Jump target already in ALUOut; ALU forms old PC + 4 for the link.
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_update_s = 1'b1;
        state_d     = S_ALUWB;
      end
      S_JALR1: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        state_d     = S_JALR2;
      end
      S_LUI: begin
        alu_src_a_s = 2'b11;
        alu_src_b_s = 2'b01;
        state_d     = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        state_d     = S_ALUWB;
      end
      S_TRAP: begin
        illegal_s = 1'b1;
        state_d   = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: imm_src_s = 3'b000;
      OP_STORE:                 imm_src_s = 3'b001;
      OP_BRANCH:                imm_src_s = 3'b010;
      OP_JAL:                   imm_src_s = 3'b011;
      OP_LUI, OP_AUIPC:         imm_src_s = 3'b100;
      default:                  imm_src_s = 3'b000;
    endcase
  end

  // Strobes are gated by rst_n so nothing writes while reset is held.
  assign pc_write   = rst_n & (pc_update_s | (branch_s & branch_cond));
  assign ir_write   = rst_n & ir_write_s;
  assign mem_write  = rst_n & mem_write_s;
  assign reg_write  = rst_n & reg_write_s;
  assign adr_src    = adr_src_s;
  assign result_src = result_src_s;
  assign alu_src_a  = alu_src_a_s;
  assign alu_src_b  = alu_src_b_s;
  assign alu_op     = alu_op_s;
  assign is_imm     = is_imm_s;
  assign imm_src    = imm_src_s;
  assign illegal    = illegal_s;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: walks each instruction class cycle by cycle
// and compares the full output vector against hand-written expectations.
module tb_control_fsm;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       branch_cond;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       is_imm;
  logic [2:0] imm_src;
  logic       illegal;

  int total;
  int passed;
  int failed;

  logic [17:0] obs;

  control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_cond(branch_cond),
    .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .is_imm(is_imm), .imm_src(imm_src), .illegal(illegal)
  );

  assign obs = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, alu_op, is_imm, imm_src, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Order: pcw adr mw irw rw | rs a b op | imm isrc ill
  function automatic logic [17:0] v(input logic pcw, input logic adr, input logic mw,
                                    input logic irw, input logic rw, input logic [1:0] rs,
                                    input logic [1:0] a, input logic [1:0] b,
                                    input logic [1:0] op, input logic imm,
                                    input logic [2:0] isrc, input logic ill);
    return {pcw, adr, mw, irw, rw, rs, a, b, op, imm, isrc, ill};
  endfunction

  function automatic logic [17:0] fetch_v(input logic [2:0] isrc);
    return v(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, isrc, 1'b0);
  endfunction

  function automatic logic [17:0] stall_v(input logic [2:0] isrc);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, isrc, 1'b0);
  endfunction

  function automatic logic [17:0] decode_v(input logic [2:0] isrc);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, isrc, 1'b0);
  endfunction

  function automatic logic [17:0] aluwb_v(input logic [2:0] isrc);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, isrc, 1'b0);
  endfunction

  function automatic logic [17:0] memadr_v(input logic [2:0] isrc);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, isrc, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [17:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One cycle slot: drive inputs just after the falling edge, settle, then check.
  task automatic slot(input logic rst, input logic mr, input logic bc);
    @(negedge clk);
    rst_n       = rst;
    mem_ready   = mr;
    branch_cond = bc;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0; passed = 0; failed = 0;
    rst_n = 1'b0; mem_ready = 1'b1; branch_cond = 1'b0; opcode = 7'b0110011;

    // Reset held with mem_ready high: strobes stay low, selects at FETCH values
    for (int i = 0; i < 3; i++) begin
      slot(1'b0, 1'b1, 1'b0);
      chk("reset_hold", stall_v(3'b000));
    end

    // R-type: FETCH, DECODE, EXECR, ALUWB
    slot(1'b1, 1'b1, 1'b0); chk("r_fetch", fetch_v(3'b000));
    slot(1'b1, 1'b1, 1'b0); chk("r_decode", decode_v(3'b000));
    slot(1'b1, 1'b1, 1'b0);
    chk("r_execr", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 3'b000, 1'b0));
    slot(1'b1, 1'b1, 1'b0); chk("r_aluwb", aluwb_v(3'b000));

    // OP-IMM, with one fetch stall cycle first
    opcode = 7'b0010011;
    slot(1'b1, 1'b0, 1'b0); chk("i_fetch_stall", stall_v(3'b000));
    slot(1'b1, 1'b1, 1'b0); chk("i_fetch", fetch_v(3'b000));
    slot(1'b1, 1'b1, 1'b0); chk("i_decode", decode_v(3'b000));
    slot(1'b1, 1'b1, 1'b0);
    chk("i_execi", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b1, 3'b000, 1'b0));
    slot(1'b1, 1'b1, 1'b0); chk("i_aluwb", aluwb_v(3'b000));

    // Load with two wait cycles in MEMREAD
    opcode = 7'b0000011;
    slot(1'b1, 1'b1, 1'b0); chk("ld_fetch", fetch_v(3'b000));
    slot(1'b1, 1'b1, 1'b0); chk("ld_decode", decode_v(3'b000));
    slot(1'b1, 1'b1, 1'b0); chk("ld_memadr", memadr_v(3'b000));
    slot(1'b1, 1'b0, 1'b0);
    chk("ld_memread_w1", v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0));
    slot(1'b1, 1'b0, 1'b0);
    chk("ld_memread_w2", v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0));
    slot(1'b1, 1'b1, 1'b0);
    chk("ld_memread", v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0));
    slot(1'b1, 1'b1, 1'b0);
    chk("ld_memwb", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0));

    // Store with one wait cycle; strobe held during the stall
    opcode = 7'b0100011;
    slot(1'b1, 1'b1, 1'b0); chk("st_fetch", fetch_v(3'b001));
    slot(1'b1, 1'b1, 1'b0); chk("st_decode", decode_v(3'b001));
    slot(1'b1, 1'b1, 1'b0); chk("st_memadr", memadr_v(3'b001));
    slot(1'b1, 1'b0, 1'b0);
    chk("st_memwrite_w", v(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0));
    slot(1'b1, 1'b1, 1'b0);
    chk("st_memwrite", v(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0));

    // Second store aborted by an asynchronous reset inside MEMWRITE
    slot(1'b1, 1'b1, 1'b0); chk("st2_fetch", fetch_v(3'b001));
    slot(1'b1, 1'b1, 1'b0); chk("st2_decode", decode_v(3'b001));
    slot(1'b1, 1'b1, 1'b0); chk("st2_memadr", memadr_v(3'b001));
    slot(1'b1, 1'b1, 1'b0);
    chk("st2_memwrite", v(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0));
    #2 rst_n = 1'b0;
    #1 chk("async_abort", stall_v(3'b001));
    slot(1'b0, 1'b1, 1'b0); chk("abort_hold", stall_v(3'b001));

    // Branch taken, then not taken
    opcode = 7'b1100011;
    slot(1'b1, 1'b1, 1'b0); chk("bt_fetch", fetch_v(3'b010));
    slot(1'b1, 1'b1, 1'b0); chk("bt_decode", decode_v(3'b010));
    slot(1'b1, 1'b1, 1'b1);
    chk("bt_branch", v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 3'b010, 1'b0));
    slot(1'b1, 1'b1, 1'b1); chk("bn_fetch", fetch_v(3'b010));
    slot(1'b1, 1'b1, 1'b1); chk("bn_decode", decode_v(3'b010));
    slot(1'b1, 1'b1, 1'b0);
    chk("bn_branch", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 3'b010, 1'b0));

    // JALR: JALR1, JALR2 (pc_write), ALUWB
    opcode = 7'b1100111;
    slot(1'b1, 1'b1, 1'b0); chk("jalr_fetch", fetch_v(3'b000));
    slot(1'b1, 1'b1, 1'b0); chk("jalr_decode", decode_v(3'b000));
    slot(1'b1, 1'b1, 1'b0); chk("jalr1", memadr_v(3'b000));
    slot(1'b1, 1'b1, 1'b0);
    chk("jalr2", v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 3'b000, 1'b0));
    slot(1'b1, 1'b1, 1'b0); chk("jalr_aluwb", aluwb_v(3'b000));

    // JAL
    opcode = 7'b1101111;
    slot(1'b1, 1'b1, 1'b0); chk("jal_fetch", fetch_v(3'b011));
    slot(1'b1, 1'b1, 1'b0); chk("jal_decode", decode_v(3'b011));
    slot(1'b1, 1'b1, 1'b0);
    chk("jal", v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 3'b011, 1'b0));
    slot(1'b1, 1'b1, 1'b0); chk("jal_aluwb", aluwb_v(3'b011));

    // LUI
    opcode = 7'b0110111;
    slot(1'b1, 1'b1, 1'b0); chk("lui_fetch", fetch_v(3'b100));
    slot(1'b1, 1'b1, 1'b0); chk("lui_decode", decode_v(3'b100));
    slot(1'b1, 1'b1, 1'b0);
    chk("lui", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 2'b01, 2'b00, 1'b0, 3'b100, 1'b0));
    slot(1'b1, 1'b1, 1'b0); chk("lui_aluwb", aluwb_v(3'b100));

    // AUIPC
    opcode = 7'b0010111;
    slot(1'b1, 1'b1, 1'b0); chk("auipc_fetch", fetch_v(3'b100));
    slot(1'b1, 1'b1, 1'b0); chk("auipc_decode", decode_v(3'b100));
    slot(1'b1, 1'b1, 1'b0); chk("auipc", decode_v(3'b100));
    slot(1'b1, 1'b1, 1'b0); chk("auipc_aluwb", aluwb_v(3'b100));

    // Illegal opcode: trap is sticky and silent until reset
    opcode = 7'b1111111;
    slot(1'b1, 1'b1, 1'b0); chk("trap_fetch", fetch_v(3'b000));
    slot(1'b1, 1'b1, 1'b0); chk("trap_decode", decode_v(3'b000));
    for (int i = 0; i < 10; i++) begin
      slot(1'b1, i[0], 1'b1);
      chk("trap_hold", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b1));
    end
    slot(1'b0, 1'b1, 1'b0); chk("trap_reset", stall_v(3'b000));
    opcode = 7'b0110011;
    slot(1'b1, 1'b1, 1'b0); chk("post_trap_fetch", fetch_v(3'b000));
    slot(1'b1, 1'b1, 1'b0); chk("post_trap_decode", decode_v(3'b000));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle RV32I main control unit: a Moore state machine that sequences fetch, decode, execute, memory and writeback for each instruction. It drives every datapath mux select and write strobe, and produces the `alu_op`/`is_imm` pair consumed by the ALU decoder. Stalls on a single-bit memory ready handshake. Latches an illegal-opcode trap.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `opcode`  in  7  instruction register bits [6:0].
- `branch_cond`  in  1  ALU comparison result; 1 = branch condition satisfied.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_write`  out  1  PC load enable.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = result bus.
- `mem_write`  out  1  memory write strobe.
- `ir_write`  out  1  IR and old-PC load enable.
- `reg_write`  out  1  register file write enable.
- `result_src`  out  2  result select: 00 = ALUOut register, 01 = read-data register, 10 = ALU result.
- `alu_src_a`  out  2  A select: 00 = PC, 01 = old PC, 10 = rs1 register, 11 = zero.
- `alu_src_b`  out  2  B select: 00 = rs2 register, 01 = immediate, 10 = constant 4.
- `alu_op`  out  2  00 = add, 01 = branch compare, 10 = funct-decoded.
- `is_imm`  out  1  1 for OP-IMM execute.
- `imm_src`  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- `illegal`  out  1  sticky trap flag.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR1, JALR2, LUI, AUIPC, TRAP.
- Any output not listed for a state is 0.
- `imm_src` is combinational from `opcode` in every state:
  - I for 0000011, 0010011, 1100111.
  - S for 0100011.
  - B for 1100011.
  - J for 1101111.
  - U for 0110111, 0010111.
  - 000 otherwise.
- `pc_write` = `pc_update` | (`branch` & `branch_cond`). `pc_update` and `branch` are internal Moore signals.
- FETCH: `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10.
  - `ir_write` = `pc_update` = `mem_ready`.
  - Stays in FETCH until `mem_ready`=1, then goes to DECODE.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (precomputes the branch target). Next state by `opcode`:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BRANCH.
  - 1101111 → JAL.
  - 1100111 → JALR1.
  - 0110111 → LUI.
  - 0010111 → AUIPC.
  - Any other value → TRAP.
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00. Goes to MEMREAD for load, MEMWRITE for store.
- MEMREAD: `adr_src`=1, `result_src`=00. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1. Goes to FETCH.
- MEMWRITE: `adr_src`=1, `result_src`=00, `mem_write`=1.
  - Strobe stays high while waiting.
  - Goes to FETCH on `mem_ready`.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10, `is_imm`=0. Goes to ALUWB.
- EXECI: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10, `is_imm`=1. Goes to ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1. Goes to FETCH.
- BRANCH: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `branch`=1. Goes to FETCH.
- JAL: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `result_src`=00, `pc_update`=1. Goes to ALUWB (writes old PC+4).
- JALR1: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00. Goes to JALR2.
- JALR2: same outputs as JAL. Goes to ALUWB.
- LUI: `alu_src_a`=11, `alu_src_b`=01, `alu_op`=00. Goes to ALUWB.
- AUIPC: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00. Goes to ALUWB.
- TRAP: all strobes 0, `illegal`=1. Remains in TRAP until reset.

## Timing
- State register updates on the rising edge of `clk`. Outputs are Moore-decoded from state. Exceptions: `ir_write`, `pc_write` and `imm_src` also depend combinationally on inputs.
- `rst_n` low: state → FETCH asynchronously, `illegal` → 0.
  - All strobes (`pc_write`, `ir_write`, `mem_write`, `reg_write`) are forced to 0 while `rst_n` is low, regardless of `mem_ready`.
  - Select outputs take their FETCH values.
- Reset asserted mid-instruction aborts it immediately. No partial write occurs after the asserting edge.
- Cycles per instruction with `mem_ready` tied to 1:
  - 3: branch.
  - 4: R-type, I-type, store, JAL, LUI, AUIPC.
  - 5: load, JALR.
- Each cycle `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs are held stable during the stall.
- `mem_ready` is ignored in all other states.
- `branch_cond` is sampled only in BRANCH.

## Test plan
- Reset with `mem_ready`=1, `rst_n` low for 3 cycles → all strobes 0, state FETCH, `illegal`=0. After release, first edge gives `ir_write`=1 and `pc_write`=1 for exactly 1 cycle.
- `opcode`=0110011 with `mem_ready`=1 → FETCH, DECODE, EXECR (`alu_op`=10, `is_imm`=0), ALUWB (`reg_write`=1) → FETCH, 4 cycles total. Repeat with 0010011 → `is_imm`=1 in EXECI.
- `opcode`=0000011, `mem_ready` low for 2 cycles in MEMREAD → 7 cycles total; `reg_write` pulses once, in MEMWB with `result_src`=01.
- `opcode`=1100011 with `branch_cond`=1 → `pc_write`=1 in BRANCH. With `branch_cond`=0 → `pc_write`=0. `alu_op`=01 and `imm_src`=010 in both cases.
- `opcode`=1100111 → JALR1, then JALR2 (`pc_write`=1), then ALUWB (`reg_write`=1, `result_src`=00), 5 cycles total.
- `opcode`=1111111 → TRAP, `illegal`=1 held for 10 cycles with no strobes. `rst_n` pulse → `illegal`=0, state FETCH.
